fp_sqrt_pipe: RTL and testbench

FP_SQRT_PIPE -- requirements
Module: fp_sqrt_pipe

---
 rtl/fp_pkg.sv | 11 +
 rtl/fp_sqrt_stage.sv | 48 ++++
 rtl/fp_sqrt_pipe.sv | 118 +++++++++++
 tb/tb_fp_sqrt_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and helpers for the pipelined floating-point units.
package fp_pkg;
  localparam int FLAG_INVALID = 0;
  localparam int FLAG_INEXACT = 1;
  function automatic int sqrt_lat(input int mant_w);
    return mant_w + 4;
  endfunction
  function automatic logic [127:0] canon_qnan(input int exp_w, input int mant_w);
    return (((128'd1 << exp_w) - 128'd1) << mant_w) | (128'd1 << (mant_w - 1));
  endfunction
endpackage

// File: rtl/fp_sqrt_stage.sv
// fp_sqrt_stage: one registered restoring square-root step, consuming two radicand bits
// and producing one root bit; the whole stage freezes when en_i is low.
module fp_sqrt_stage #(
  parameter int N  = 12,
  parameter int MW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           valid_i,
  input  logic [2*N-1:0] rad_i,
  input  logic [N:0]     rem_i,
  input  logic [N-1:0]   root_i,
  input  logic [MW-1:0]  meta_i,
  output logic           valid_o,
  output logic [2*N-1:0] rad_o,
  output logic [N:0]     rem_o,
  output logic [N-1:0]   root_o,
  output logic [MW-1:0]  meta_o
);
  logic [N+2:0] cur, trial;
  logic fit;
  logic valid_q;
  logic [2*N-1:0] rad_q;
  logic [N:0] rem_q;
  logic [N-1:0] root_q;
  logic [MW-1:0] meta_q;
  always_comb begin
    cur = {rem_i, rad_i[2*N-1 -: 2]};
    trial = {1'b0, root_i, 2'b01};
    fit = cur >= trial;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else if (en_i) valid_q <= valid_i;
    if (en_i) begin
      rad_q <= {rad_i[2*N-3:0], 2'b00};
      rem_q <= (N+1)'(fit ? cur - trial : cur);
      root_q <= {root_i[N-2:0], fit};
      meta_q <= meta_i;
    end
  end
  assign valid_o = valid_q;
  assign rad_o = rad_q;
  assign rem_o = rem_q;
  assign root_o = root_q;
  assign meta_o = meta_q;
endmodule

// File: rtl/fp_sqrt_pipe.sv
// fp_sqrt_pipe: fully pipelined IEEE-754 square root (unpack, one root bit per stage,
// round-to-nearest-even pack); the entire pipe stalls together on output backpressure.
module fp_sqrt_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  flag_invalid,
  output logic                  flag_inexact
);
  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int N    = sqrt_lat(MANT_W) - 2;
  localparam int EW   = EXP_W + $clog2(MANT_W + 1) + 2;
  localparam int MW   = 2 + W + EXP_W;
  localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MANT_W));
  logic [EXP_W-1:0] expf, rexp;
  logic [MANT_W-1:0] frac;
  logic is_nan, is_zero, special, invalid, odd;
  logic [W-1:0] spec_res;
  logic [MANT_W:0] sig;
  logic [N-1:0] sig_d, sig_q;
  logic signed [EW-1:0] e_s, e_a, e_h;
  logic [MW-1:0] meta_d, meta_q;
  logic v0_q;
  int msb;
  always_comb begin
    expf = a[W-2:MANT_W];
    frac = a[MANT_W-1:0];
    msb = 0;
    for (int k = 0; k < MANT_W; k++) if (frac[k]) msb = k;
    is_nan = &expf && |frac;
    is_zero = ~|expf && ~|frac;
    special = &expf || is_zero || a[W-1];
    invalid = (is_nan && !frac[MANT_W-1]) || (a[W-1] && !is_zero && !is_nan);
    spec_res = is_nan ? QNAN : is_zero ? {a[W-1], {(W-1){1'b0}}} : a[W-1] ? QNAN : a;
    // subnormals are normalised so the root always sees a significand in [1,2)
    sig = ~|expf ? (MANT_W+1)'(frac) << (MANT_W - msb) : {1'b1, frac};
    e_s = ~|expf ? EW'(1 - BIAS - MANT_W + msb) : EW'(expf) - EW'(BIAS);
    odd = e_s[0];
    sig_d = odd ? {sig, 1'b0} : {1'b0, sig};
    e_a = e_s - EW'(odd);
    e_h = e_a >>> 1;
    rexp = EXP_W'(e_h + EW'(BIAS));
    meta_d = {special, invalid, spec_res, rexp};
  end
  assign in_ready = !rst_n || !(out_valid && !out_ready);
  always_ff @(posedge clk) begin
    if (!rst_n) v0_q <= 1'b0;
    else if (in_ready) v0_q <= in_valid;
    if (in_ready) begin
      sig_q <= sig_d;
      meta_q <= meta_d;
    end
  end
  logic v_w [N+1];
  logic [2*N-1:0] rad_w [N+1];
  logic [N:0] rem_w [N+1];
  logic [N-1:0] root_w [N+1];
  logic [MW-1:0] meta_w [N+1];
  assign v_w[0] = v0_q;
  assign rad_w[0] = {sig_q, {N{1'b0}}};
  assign rem_w[0] = '0;
  assign root_w[0] = '0;
  assign meta_w[0] = meta_q;
  for (genvar i = 0; i < N; i++) begin : g_stage
    fp_sqrt_stage #(.N(N), .MW(MW)) u_stage (
      .clk(clk), .rst_n(rst_n), .en_i(in_ready),
      .valid_i(v_w[i]), .rad_i(rad_w[i]), .rem_i(rem_w[i]), .root_i(root_w[i]), .meta_i(meta_w[i]),
      .valid_o(v_w[i+1]), .rad_o(rad_w[i+1]), .rem_o(rem_w[i+1]), .root_o(root_w[i+1]), .meta_o(meta_w[i+1])
    );
  end
  logic sp, guard, sticky, up;
  logic [EXP_W+MANT_W-1:0] rounded;
  logic [W-1:0] result_d, result_q;
  logic [1:0] flags_d, flags_q;
  logic out_valid_q;
  logic unused;
  always_comb begin
    sp = meta_w[N][MW-1];
    guard = root_w[N][0];
    sticky = |rem_w[N];
    up = guard && (sticky || root_w[N][1]);
    // a carry out of the fraction lands in the exponent field and leaves the fraction zero
    rounded = {meta_w[N][EXP_W-1:0], root_w[N][N-2:1]} + (EXP_W+MANT_W)'(up);
    result_d = sp ? meta_w[N][EXP_W +: W] : {1'b0, rounded};
    flags_d = '0;
    flags_d[FLAG_INVALID] = sp && meta_w[N][MW-2];
    flags_d[FLAG_INEXACT] = !sp && (guard || sticky);
  end
  assign unused = ^{root_w[N][N-1], rad_w[N]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
    end else if (in_ready) begin
      out_valid_q <= v_w[N];
      if (v_w[N]) begin
        result_q <= result_d;
        flags_q <= flags_d;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign flag_invalid = flags_q[FLAG_INVALID];
  assign flag_inexact = flags_q[FLAG_INEXACT];
endmodule

// File: tb/tb_fp_sqrt_pipe.sv
// tb_fp_sqrt_pipe: scenario tasks for fp_sqrt_pipe (fp16) checked against a real-arithmetic
// square-root reference with round-to-nearest-even.
module tb_fp_sqrt_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] a = '0;
  logic in_ready, out_valid, flag_invalid, flag_inexact;
  logic [15:0] result;
  int n_tests = 0;
  int n_fail = 0;
  logic [17:0] got [$];
  logic [15:0] sent [$];
  logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7D01, 16'hFE00, 16'hBC00};

  fp_sqrt_pipe #(.EXP_W(5), .MANT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_invalid(flag_invalid), .flag_inexact(flag_inexact)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) got.push_back({flag_invalid, flag_inexact, result});

  function automatic real pow2(input int k);
    real p = 1.0;
    for (int i = 0; i < (k < 0 ? -k : k); i++) p = (k < 0) ? p / 2.0 : p * 2.0;
    return p;
  endfunction

  function automatic void model(input logic [15:0] x, output logic [15:0] r, output logic inv, output logic inx);
    logic [4:0] ex;
    logic [9:0] fr;
    real v, s, sc, d;
    int e;
    longint fi;
    ex = x[14:10];
    fr = x[9:0];
    inv = 1'b0;
    inx = 1'b0;
    if (ex == 5'd31 && fr != 0) begin
      r = 16'h7E00;
      inv = !fr[9];
    end else if (ex == 0 && fr == 0) r = {x[15], 15'd0};
    else if (x[15]) begin
      r = 16'h7E00;
      inv = 1'b1;
    end else if (ex == 5'd31) r = 16'h7C00;
    else begin
      v = (ex == 0) ? real'(fr) * pow2(-24) : real'(1024 + int'(fr)) * pow2(int'(ex) - 25);
      s = $sqrt(v);
      e = 0;
      while (s >= 2.0) begin s = s / 2.0; e++; end
      while (s < 1.0) begin s = s * 2.0; e--; end
      sc = s * 1024.0;
      fi = longint'($floor(sc));
      d = sc - real'(fi);
      inx = (d != 0.0);
      if (d > 0.5 || (d == 0.5 && fi[0])) fi++;
      if (fi == 2048) begin fi = 1024; e++; end
      r = {1'b0, 5'(e + 15), 10'(fi - 1024)};
    end
  endfunction

  function automatic logic [15:0] gen();
    int s = $urandom_range(0, 9);
    if (s == 0) return specials[$urandom_range(0, 7)];
    if (s == 1) return {6'd0, 10'($urandom)};
    if (s == 2) return 16'($urandom);
    return {1'b0, 15'($urandom)};
  endfunction

  task automatic push(input logic [15:0] x);
    int t = 0;
    in_valid = 1'b1;
    a = x;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout a=%h in_ready=%b want 1", x, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sent.push_back(x);
  endtask

  task automatic wait_results(input int n, output bit ok);
    int t = 0;
    while (got.size() < n && t < 5000) begin @(posedge clk); t++; end
    repeat (20) @(posedge clk);
    #1 ok = (got.size() == n);
  endtask

  task automatic settle();
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    got.delete();
    sent.delete();
  endtask

  task automatic measure(input logic [15:0] x, output int cyc);
    cyc = 0;
    in_valid = 1'b1;
    a = x;
    @(posedge clk);
    cyc = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && cyc < 100) begin @(posedge clk); cyc++; #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h4400;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({out_valid, flag_invalid, flag_inexact, result, in_ready} !== {3'b000, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got ov=%b fi=%b fx=%b res=%h ir=%b want 0 0 0 0000 1",
               out_valid, flag_invalid, flag_inexact, result, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    settle();
  endtask

  task automatic test_directed();
    logic [15:0] din [12] = '{16'h4400, 16'h4000, 16'h0001, 16'hC000, 16'h7D00, 16'h7E00,
                              16'h8000, 16'h7C00, 16'h3C00, 16'h7BFF, 16'hFC00, 16'hFE00};
    logic [17:0] want [12] = '{{2'b00, 16'h4000}, {2'b01, 16'h3DA8}, {2'b00, 16'h0C00}, {2'b10, 16'h7E00},
                               {2'b10, 16'h7E00}, {2'b00, 16'h7E00}, {2'b00, 16'h8000}, {2'b00, 16'h7C00},
                               {2'b00, 16'h3C00}, {2'b01, 16'h5BFF}, {2'b10, 16'h7E00}, {2'b00, 16'h7E00}};
    int cyc;
    bit ok;
    measure(16'h4400, cyc);
    n_tests++;
    if (cyc !== 14 || result !== 16'h4000) begin
      n_fail++;
      $display("FAIL latency_4p0 got %0d cycles res=%h want 14 cycles res=4000", cyc, result);
    end
    settle();
    foreach (din[i]) push(din[i]);
    wait_results(12, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL directed_count got %0d want 12", got.size()); end
    foreach (din[i]) if (i < got.size()) begin
      n_tests++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL directed a=%h got %h want %h", din[i], got[i], want[i]);
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic iv, ix;
    bit ok;
    fork
      for (int i = 0; i < 20; i++) push({1'b0, 15'($urandom)});
      begin
        repeat (16) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          n_tests++;
          if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready cycle %0d got %b want 0", 16 + c, in_ready);
          end
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    wait_results(20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_count got %0d want 20", got.size()); end
    foreach (sent[i]) if (i < got.size()) begin
      model(sent[i], r, iv, ix);
      n_tests++;
      if (got[i] !== {iv, ix, r}) begin
        n_fail++;
        $display("FAIL b2b[%0d] a=%h got %h want %h", i, sent[i], got[i], {iv, ix, r});
      end
    end
    settle();
  endtask

  task automatic test_reset_flush();
    int cyc;
    int seen = 0;
    for (int i = 0; i < 5; i++) push(16'h4400 + 16'(i * 64));
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen != 0 || got.size() != 0) begin
      n_fail++;
      $display("FAIL flush_out_valid got %0d valid cycles %0d results want 0 0", seen, got.size());
    end
    @(posedge clk); #1;
    measure(16'h4000, cyc);
    n_tests++;
    if (cyc !== 14 || result !== 16'h3DA8 || flag_inexact !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_latency got %0d cycles res=%h inx=%b want 14 cycles res=3da8 inx=1",
               cyc, result, flag_inexact);
    end
    settle();
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic iv, ix;
    bit ok;
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) push(gen());
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0); end
        out_ready = 1'b1;
      end
    join
    wait_results(400, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rand_count got %0d want 400", got.size()); end
    foreach (sent[i]) if (i < got.size()) begin
      model(sent[i], r, iv, ix);
      n_tests++;
      if (got[i] !== {iv, ix, r}) begin
        n_fail++;
        $display("FAIL rand[%0d] a=%h got %h want %h", i, sent[i], got[i], {iv, ix, r});
      end
    end
    settle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
